// File: rtl/mem_sp_arb_ctrl.sv
// Round-robin arbiter sharing one single-port sync RAM between P0 and P1, with optional
// zero-fill after reset. Grants are same-cycle; read data returns one cycle after grant.
module mem_sp_arb_ctrl #(
  parameter int DEPTH          = 2048,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int DATA_BYTES     = DATA_WIDTH / 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_p0_req,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [DATA_WIDTH-1:0] i_p0_wdata,
  input  logic [DATA_BYTES-1:0] i_p0_wen,
  output logic                  o_p0_gnt,
  output logic                  o_p0_rvalid,
  output logic [DATA_WIDTH-1:0] o_p0_rdata,
  input  logic                  i_p1_req,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  input  logic [DATA_BYTES-1:0] i_p1_wen,
  output logic                  o_p1_gnt,
  output logic                  o_p1_rvalid,
  output logic [DATA_WIDTH-1:0] o_p1_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_init_done
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam state_t                LP_RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_rr_last;
  logic                  r_p0_rvalid;
  logic                  r_p1_rvalid;
  logic                  r_init_done;

  logic w_run;
  logic w_p0_gnt;
  logic w_p1_gnt;

  // r_rr_last: 1 means P1 was served most recently, so a tie goes to P0.
  assign w_run    = (r_state == S_RUN) && !rst;
  assign w_p0_gnt = w_run && i_p0_req && (!i_p1_req || r_rr_last);
  assign w_p1_gnt = w_run && i_p1_req && (!i_p0_req || !r_rr_last);

  always_comb begin
    o_mem_addr  = i_p0_addr;
    o_mem_wdata = i_p0_wdata;
    o_mem_wen   = '0;
    if (rst) begin
      o_mem_wen = '0;
    end else if (r_state == S_CLEAR) begin
      o_mem_addr  = r_clr_cnt;
      o_mem_wdata = '0;
      o_mem_wen   = '1;
    end else if (w_p1_gnt) begin
      o_mem_addr  = i_p1_addr;
      o_mem_wdata = i_p1_wdata;
      o_mem_wen   = i_p1_wen;
    end else if (w_p0_gnt) begin
      o_mem_wen   = i_p0_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LP_RST_STATE;
      r_clr_cnt   <= '0;
      r_rr_last   <= 1'b1;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_p0_rvalid <= w_p0_gnt && (i_p0_wen == '0);
      r_p1_rvalid <= w_p1_gnt && (i_p1_wen == '0);
      if (r_state == S_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == LP_LAST_ADDR) begin
          r_state     <= S_RUN;
          r_init_done <= 1'b1;
        end
      end else begin
        r_init_done <= 1'b1;
        if (w_p0_gnt) begin
          r_rr_last <= 1'b0;
        end else if (w_p1_gnt) begin
          r_rr_last <= 1'b1;
        end
      end
    end
  end

  // A read accepted just before reset must not surface while reset is held.
  assign o_p0_rvalid = r_p0_rvalid && !rst;
  assign o_p1_rvalid = r_p1_rvalid && !rst;
  assign o_p0_rdata  = i_mem_rdata;
  assign o_p1_rdata  = i_mem_rdata;
  assign o_p0_gnt    = w_p0_gnt;
  assign o_p1_gnt    = w_p1_gnt;
  assign o_init_done = r_init_done;

endmodule
